// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
// Holds the opcode constants, immediate-select codes, ALU operation codes,
// FSM state encoding, error codes and the bundled control-output record.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [2:0] IMM_I_ALU  = 3'b000;
    localparam logic [2:0] IMM_I_LOAD = 3'b001;
    localparam logic [2:0] IMM_S      = 3'b010;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_FAULT
    } state_t;

    // All control outputs in one record so reset gating is a single mux.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [3:0] alu_control;
        logic       instr_done;
        logic       error;
        logic [1:0] err_code;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports:
//   funct3     in  3  instr[14:12]
//   funct7_5   in  1  instr[30]
//   is_rtype   in  1  1 = register-register op, 0 = immediate op
//   alu_control out 4 selected ALU operation
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output alu_ctrl_t  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            // instr[30] selects SRA for both SRA and SRAI
            3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RISC-V control unit for loads, stores, R-type and I-type ALU ops.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   op, funct3, funct7_5       instruction fields
//   mem_ready                  memory completes current request
//   mem_req, mem_we, adr_src   memory interface controls
//   ir_write, pc_write, reg_write  register write strobes
//   alu_src_a, alu_src_b, result_src, imm_src, alu_control  datapath selects
//   instr_done                 retirement pulse
//   error, err_code            sticky fault flag and cause
//
// state    | meaning
// FETCH    | request instruction at PC, PC+4 through ALU
// DECODE   | classify opcode
// MEMADR   | rs1 + imm address computation
// MEMREAD  | load request at ALUOut
// MEMWB    | write loaded data to register file
// MEMWRITE | store request at ALUOut
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// ALUWB    | write ALUOut to register file
// FAULT    | illegal opcode or memory timeout, held until reset
module mc_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    state_t      state, state_next;
    logic [CW-1:0] wait_cnt;
    logic [1:0]  err_q, err_next;
    logic        waiting;
    logic        timeout;
    alu_ctrl_t   dec_alu;
    ctrl_t       ctrl_raw, ctrl;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .is_rtype    (state == S_EXEC_R),
        .alu_control (dec_alu)
    );

    assign waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // This not-ready cycle would be the WAIT_LIMIT-th in a row; a ready on
    // the same cycle is not a timeout, so completion wins.
    assign timeout = waiting && !mem_ready && (wait_cnt == CW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state <= state_next;
            err_q <= err_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        state_next           = state;
        err_next             = err_q;
        ctrl_raw             = '0;
        ctrl_raw.alu_control = ALU_ADD;
        ctrl_raw.imm_src     = IMM_I_ALU;
        case (state)
            S_FETCH: begin
                ctrl_raw.mem_req    = 1'b1;
                ctrl_raw.alu_src_b  = 2'b10;
                ctrl_raw.result_src = 2'b10;
                if (mem_ready) begin
                    ctrl_raw.ir_write = 1'b1;
                    ctrl_raw.pc_write = 1'b1;
                    state_next        = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (op == OP_LOAD || op == OP_STORE)
                    state_next = S_MEMADR;
                else if (op == OP_RTYPE)
                    state_next = S_EXEC_R;
                else if (op == OP_ITYPE)
                    state_next = S_EXEC_I;
                else begin
                    state_next = S_FAULT;
                    err_next   = ERR_ILLEGAL;
                end
            end
            S_MEMADR: begin
                ctrl_raw.alu_src_a = 2'b10;
                ctrl_raw.alu_src_b = 2'b01;
                if (op == OP_STORE) begin
                    ctrl_raw.imm_src = IMM_S;
                    state_next       = S_MEMWRITE;
                end else begin
                    ctrl_raw.imm_src = IMM_I_LOAD;
                    state_next       = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                ctrl_raw.mem_req = 1'b1;
                ctrl_raw.adr_src = 1'b1;
                if (mem_ready)
                    state_next = S_MEMWB;
                else if (timeout) begin
                    state_next = S_FAULT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_MEMWB: begin
                ctrl_raw.result_src = 2'b01;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.instr_done = 1'b1;
                state_next          = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl_raw.mem_req = 1'b1;
                ctrl_raw.mem_we  = 1'b1;
                ctrl_raw.adr_src = 1'b1;
                if (mem_ready) begin
                    ctrl_raw.instr_done = 1'b1;
                    state_next          = S_FETCH;
                end else if (timeout) begin
                    state_next = S_FAULT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_EXEC_R: begin
                ctrl_raw.alu_src_a   = 2'b10;
                ctrl_raw.alu_src_b   = 2'b00;
                ctrl_raw.alu_control = dec_alu;
                state_next           = S_ALUWB;
            end
            S_EXEC_I: begin
                ctrl_raw.alu_src_a   = 2'b10;
                ctrl_raw.alu_src_b   = 2'b01;
                ctrl_raw.imm_src     = IMM_I_ALU;
                ctrl_raw.alu_control = dec_alu;
                state_next           = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_raw.result_src = 2'b00;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.instr_done = 1'b1;
                state_next          = S_FETCH;
            end
            S_FAULT: begin
                ctrl_raw.error    = 1'b1;
                ctrl_raw.err_code = err_q;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Outputs are forced low for the whole time reset is held, not just at
    // the edge, since the reset state itself would otherwise request memory.
    assign ctrl = rst_n ? ctrl_raw : '0;

    assign mem_req     = ctrl.mem_req;
    assign mem_we      = ctrl.mem_we;
    assign adr_src     = ctrl.adr_src;
    assign ir_write    = ctrl.ir_write;
    assign pc_write    = ctrl.pc_write;
    assign reg_write   = ctrl.reg_write;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign result_src  = ctrl.result_src;
    assign imm_src     = ctrl.imm_src;
    assign alu_control = ctrl.alu_control;
    assign instr_done  = ctrl.instr_done;
    assign error       = ctrl.error;
    assign err_code    = ctrl.err_code;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit (WAIT_LIMIT = 4).
module tb_mc_control_unit;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [3:0] alu_control;
        logic       instr_done;
        logic       error;
        logic [1:0] err_code;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          fw;
        int          mw;
        int          exp_done;
        logic [3:0]  exp_alu;
        logic [2:0]  exp_imm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       instr_done, error;
    logic [1:0] err_code;
    out_t       dut_out;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_seen = 0;
    logic [3:0] f3_op [8];

    mc_control_unit #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
        .error(error), .err_code(err_code)
    );

    assign dut_out = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                      alu_src_a, alu_src_b, result_src, imm_src, alu_control,
                      instr_done, error, err_code};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input bit is_r);
        logic [3:0] r;
        r = f3_op[f3];
        if (f3 == 3'd0 && is_r && f7) r = 4'b0001;
        if (f3 == 3'd5 && f7) r = 4'b0111;
        return r;
    endfunction

    function automatic out_t o_fetch(input bit done);
        out_t e = '0;
        e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
        e.ir_write = done; e.pc_write = done;
        return e;
    endfunction

    function automatic out_t o_memadr(input logic [2:0] imm);
        out_t e = '0;
        e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.imm_src = imm;
        return e;
    endfunction

    function automatic out_t o_memrd();
        out_t e = '0;
        e.mem_req = 1'b1; e.adr_src = 1'b1;
        return e;
    endfunction

    function automatic out_t o_memwr(input bit done);
        out_t e = '0;
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1; e.instr_done = done;
        return e;
    endfunction

    function automatic out_t o_wb(input logic [1:0] rs);
        out_t e = '0;
        e.result_src = rs; e.reg_write = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic out_t o_exec(input bit is_r, input logic [3:0] alu);
        out_t e = '0;
        e.alu_src_a = 2'b10; e.alu_src_b = is_r ? 2'b00 : 2'b01; e.alu_control = alu;
        return e;
    endfunction

    function automatic out_t o_fault(input logic [1:0] code);
        out_t e = '0;
        e.error = 1'b1; e.err_code = code;
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_out(input string nm, input out_t exp);
        n_checks++;
        if (dut_out === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, dut_out, exp);
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Entered just after a rising edge; drives inputs, samples, advances one cycle.
    task automatic step(input logic rdy, input out_t exp, input string nm);
        mem_ready = rdy;
        #1;
        check_out(nm, exp);
        if (instr_done === 1'b1) done_seen = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_out("reset_gate", '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic mem_phase(input out_t busy, input out_t fin, input int waits,
                             input string nm, output bit faulted);
        faulted = 1'b0;
        for (int i = 0; i < waits && i < LIMIT; i++) step(1'b0, busy, nm);
        if (waits >= LIMIT) faulted = 1'b1;
        else step(1'b1, fin, nm);
    endtask

    task automatic fault_tail(input logic [1:0] code);
        step(1'($urandom_range(0, 1)), o_fault(code), "fault_hold");
        step(1'($urandom_range(0, 1)), o_fault(code), "fault_hold");
        do_reset();
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input bit use_tab, input logic [3:0] t_alu,
                             input logic [2:0] t_imm, output int done_at);
        bit f;
        logic [3:0] alu_e;
        logic [2:0] imm_e;
        op = ins[6:0];
        funct3 = ins[14:12];
        funct7_5 = ins[30];
        done_seen = 0;
        cyc = 1;
        done_at = 0;
        mem_phase(o_fetch(1'b0), o_fetch(1'b1), fw, "fetch", f);
        if (f) begin
            fault_tail(2'b10);
            return;
        end
        step(1'($urandom_range(0, 1)), out_t'(0), "decode");
        case (ins[6:0])
            7'b0000011: begin
                imm_e = use_tab ? t_imm : 3'b001;
                step(1'($urandom_range(0, 1)), o_memadr(imm_e), "memadr_ld");
                mem_phase(o_memrd(), o_memrd(), mw, "memread", f);
                if (f) begin fault_tail(2'b10); return; end
                step(1'($urandom_range(0, 1)), o_wb(2'b01), "memwb");
            end
            7'b0100011: begin
                imm_e = use_tab ? t_imm : 3'b010;
                step(1'($urandom_range(0, 1)), o_memadr(imm_e), "memadr_st");
                mem_phase(o_memwr(1'b0), o_memwr(1'b1), mw, "memwrite", f);
                if (f) begin fault_tail(2'b10); return; end
            end
            7'b0110011, 7'b0010011: begin
                alu_e = use_tab ? t_alu : ref_alu(ins[14:12], ins[30], ins[5]);
                step(1'($urandom_range(0, 1)), o_exec(ins[5], alu_e), "exec");
                step(1'($urandom_range(0, 1)), o_wb(2'b00), "aluwb");
            end
            default: begin
                fault_tail(2'b01);
                return;
            end
        endcase
        done_at = done_seen;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vecs[$];
        int   d;
        logic [31:0] ins;

        f3_op = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0011, 4'b0010};

        vecs.push_back('{"addi",      32'h00500093, 0, 0, 4,  4'b0000, 3'b000});
        vecs.push_back('{"sw_wait3",  32'h0020a023, 0, 3, 7,  4'b0000, 3'b010});
        vecs.push_back('{"lw",        32'h0000a103, 0, 0, 5,  4'b0000, 3'b001});
        vecs.push_back('{"sub",       32'h40208033, 0, 0, 4,  4'b0001, 3'b000});
        vecs.push_back('{"srai",      32'h4030D093, 0, 0, 4,  4'b0111, 3'b000});
        vecs.push_back('{"addi_b30",  32'h40008093, 0, 0, 4,  4'b0000, 3'b000});
        vecs.push_back('{"sltu",      32'h0020B033, 0, 0, 4,  4'b1001, 3'b000});
        vecs.push_back('{"and_f7",    32'h4020F033, 0, 0, 4,  4'b0010, 3'b000});
        vecs.push_back('{"srl",       32'h0020D033, 0, 0, 4,  4'b0110, 3'b000});
        vecs.push_back('{"lw_wait33", 32'h0000a103, 3, 3, 11, 4'b0000, 3'b001});
        vecs.push_back('{"illegal",   32'h0000007F, 0, 0, 0,  4'b0000, 3'b000});
        vecs.push_back('{"fetch_to",  32'h00500093, 4, 0, 0,  4'b0000, 3'b000});
        vecs.push_back('{"memrd_to",  32'h0000a103, 0, 4, 0,  4'b0000, 3'b001});
        vecs.push_back('{"memwr_to",  32'h0020a023, 0, 4, 0,  4'b0000, 3'b010});

        @(posedge clk);
        #1;
        do_reset();

        foreach (vecs[i]) begin
            run_instr(vecs[i].ins, vecs[i].fw, vecs[i].mw, 1'b1,
                      vecs[i].exp_alu, vecs[i].exp_imm, d);
            check_int({vecs[i].name, "_done_cycle"}, d, vecs[i].exp_done);
        end

        // reset in the middle of an R-type execute cycle
        op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        cyc = 1;
        step(1'b1, o_fetch(1'b1), "rst_mid_fetch");
        step(1'b0, out_t'(0), "rst_mid_decode");
        mem_ready = 1'b1;
        #1;
        check_out("rst_mid_exec", o_exec(1'b1, 4'b0001));
        do_reset();
        run_instr(32'h00500093, 0, 0, 1'b1, 4'b0000, 3'b000, d);
        check_int("after_reset_done_cycle", d, 4);

        // randomized instruction mix against the reference model
        for (int n = 0; n < 60; n++) begin
            int cls;
            int fw, mw, exp;
            ins = $urandom;
            cls = int'($urandom_range(0, 9));
            fw = int'($urandom_range(0, LIMIT - 1));
            mw = int'($urandom_range(0, LIMIT - 1));
            if ($urandom_range(0, 15) == 0) fw = LIMIT;
            if ($urandom_range(0, 15) == 0) mw = LIMIT;
            case (cls)
                0, 1:    ins[6:0] = 7'b0000011;
                2, 3:    ins[6:0] = 7'b0100011;
                4, 5, 6: ins[6:0] = 7'b0110011;
                7, 8:    ins[6:0] = 7'b0010011;
                default: begin
                    while (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011 ||
                           ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011)
                        ins[6:0] = 7'($urandom);
                end
            endcase
            // retirement cycle from the phase lengths: fetch waits+1, decode 1, then per class
            if (fw >= LIMIT || cls == 9) exp = 0;
            else if (cls <= 1) exp = (mw >= LIMIT) ? 0 : fw + 1 + 1 + 1 + mw + 1 + 1;
            else if (cls <= 3) exp = (mw >= LIMIT) ? 0 : fw + 1 + 1 + 1 + mw + 1;
            else exp = fw + 1 + 1 + 1 + 1;
            run_instr(ins, fw, mw, 1'b0, 4'b0000, 3'b000, d);
            check_int("rand_done_cycle", d, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 16: maximum memory-wait cycles before a bus error.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 op  in  7  instr[6:0] from the instruction register.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7_5  in  1  instr[30].
REQ-007 mem_ready  in  1  memory completes the current request this cycle.
REQ-008 mem_req / mem_we  out  1 / 1  memory request and write enable.
REQ-009 adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 ir_write / pc_write / reg_write  out  1 each  register write strobes.
REQ-011 alu_src_a  out  2  00 = PC, 10 = rs1.
REQ-012 alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4.
REQ-013 result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALU result direct.
REQ-014 imm_src  out  3  000 = I-ALU, 001 = I-load, 010 = S-store; drives the immediate generator.
REQ-015 alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
REQ-016 instr_done  out  1  one-cycle pulse on instruction retirement.
REQ-017 error  out  1  sticky fault flag.
REQ-018 err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Function
REQ-019 Outputs are Moore-decoded from state, except wait-dependent strobes noted below; unlisted outputs are 0, and imm_src and alu_control default to 000 and ADD.
REQ-020 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, FAULT.
REQ-021 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10; ir_write=pc_write=1 only in the cycle mem_ready=1; then go to DECODE, otherwise stay.
REQ-022 DECODE, one cycle: op 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; any other -> FAULT with err_code=01.
REQ-023 MEMADR: alu_src_a=10, alu_src_b=01, ADD, imm_src=001 for a load or 010 for a store; next state is MEMREAD for a load or MEMWRITE for a store.
REQ-024 MEMREAD: mem_req=1, adr_src=1; on mem_ready go to MEMWB.
REQ-025 MEMWB: result_src=01, reg_write=1, instr_done=1; then go to FETCH.
REQ-026 MEMWRITE: mem_req=mem_we=1, adr_src=1; on mem_ready, instr_done=1 and go to FETCH.
REQ-027 EXEC_R: alu_src_a=10, alu_src_b=00, alu_control from funct3 and funct7_5; then go to ALUWB.
REQ-028 EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=000; funct7_5 is honoured only for funct3=101 (SRAI), so funct3=000 is always ADD; then go to ALUWB.
REQ-029 ALUWB: result_src=00, reg_write=1, instr_done=1; then go to FETCH.
REQ-030 funct3 mapping: 000 ADD/SUB(R with f7_5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA(f7_5), 110 OR, 111 AND.
REQ-031 Wait counter, width clog2(WAIT_LIMIT+1), clears on every state change and increments each cycle in FETCH/MEMREAD/MEMWRITE while mem_ready=0.
REQ-032 Timeout: when the counter reaches WAIT_LIMIT with mem_ready=0 on that cycle, go to FAULT with err_code=10; no strobe fires on that cycle.
REQ-033 If mem_ready=1 on the cycle the counter hits the limit, completion wins and no fault is raised.
REQ-034 FAULT: all strobes 0, error=1, err_code held; exit only by reset.
REQ-035 mem_ready is ignored in states not requesting memory.

Reset
REQ-036 rst_n low asynchronously forces state=FETCH, counter=0, error=0, err_code=00.
REQ-037 While rst_n=0, all outputs are gated to 0, including mem_req.
REQ-038 Reset mid-instruction abandons it with no further strobe; the first FETCH request occurs on the first rising edge after deassertion.

Structure
REQ-039 Package riscv_ctrl_pkg holds the opcode constants, imm_src codes, alu_control enum, state enum and err_code constants.
REQ-040 Sub-module alu_decoder (combinational) maps funct3, funct7_5 and an R/I select to alu_control.

Verification
REQ-041 ADDI x1,x0,5 (0x00500093) with mem_ready tied 1 -> FETCH, DECODE, EXEC_I (imm_src=000, ADD), ALUWB (reg_write=1, instr_done=1); 4 cycles total.
REQ-042 SW (op 0100011), mem_ready delayed 3 cycles in MEMWRITE -> MEMADR imm_src=010; mem_we held 4 cycles; instr_done on the 4th cycle.
REQ-043 LW with ready=1 -> 5 cycles; MEMADR imm_src=001; MEMWB result_src=01 and reg_write=1.
REQ-044 R-type SUB (funct3=000, f7_5=1) -> alu_control=0001; SRAI (funct3=101, f7_5=1) -> 0111; ADDI with instr[30]=1 -> 0000.
REQ-045 mem_ready held 0 with WAIT_LIMIT=4 -> FAULT after 4 wait cycles, err_code=10; mem_ready=1 on the 4th cycle -> normal completion.
REQ-046 op=1111111 -> FAULT with err_code=01 and error=1; rst_n pulsed low mid-EXEC_R -> outputs 0 immediately, FETCH resumes after release.
